// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture block: FSM encodings, field widths
// and the trace-entry layout. A full entry is {cycle stamp, trace_payload_t}.
package trace_capture_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } trace_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(trace_payload_t);

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding trace entries; the head is visible on
// rdata whenever the FIFO is not empty. Pushes at full are accepted only with a pop.
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign do_pop_c  = pop & ~empty & ~clear;
    assign do_push_c = push & ~clear & (~full | do_pop_c);

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push_c) wptr_q <= wptr_q + AW'(1);
            if (do_pop_c)  rptr_q <= rptr_q + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/trace_capture.sv
// Captures processor writeback events into a cycle-stamped trace FIFO during a
// capture window bounded by arm, halt and an optional cycle limit.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CYC_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [CYC_W-1:0]         max_cycles,
    input  logic                     halt,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_rd,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     tr_ready,
    output logic                     tr_valid,
    output logic [CYC_W-1:0]         tr_cycle,
    output logic [PC_W-1:0]          tr_pc,
    output logic [REG_W-1:0]         tr_rd,
    output logic [DATA_W-1:0]        tr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [1:0]               state,
    output logic [CYC_W-1:0]         cycle
);

    localparam int unsigned ENTRY_W = CYC_W + PAYLOAD_W;

    logic [1:0]       state_q, state_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic             push_c, pop_c, drop_c, window_end_c;
    logic             full_c, empty_c;
    logic [ENTRY_W-1:0] wentry_c, rentry_c;
    trace_payload_t   wpay_c, rpay_c;

    assign push_c       = (state_q == ST_RUN) && wb_valid && (wb_rd != '0) && !clear;
    assign pop_c        = tr_ready & ~clear;
    assign drop_c       = push_c & full_c & ~pop_c;
    assign window_end_c = (max_cycles != '0) && (cycle_q == CYC_W'(max_cycles - CYC_W'(1)));

    assign wpay_c   = '{pc: wb_pc, rd: wb_rd, data: wb_data};
    assign wentry_c = {cycle_q, wpay_c};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (wentry_c),
        .rdata (rentry_c),
        .full  (full_c),
        .empty (empty_c),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // The cycle stamp freezes on the edge that closes the window
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            state_d    = ST_IDLE;
            cycle_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_RUN;
                        cycle_d = '0;
                    end
                end
                ST_RUN: begin
                    if (halt || window_end_c) state_d = ST_DONE;
                    else                      cycle_d = cycle_q + CYC_W'(1);
                end
                default: ;
            endcase
            if (drop_c) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    assign rpay_c   = trace_payload_t'(rentry_c[PAYLOAD_W-1:0]);
    assign tr_valid = ~empty_c;
    assign tr_cycle = rentry_c[ENTRY_W-1 -: CYC_W];
    assign tr_pc    = rpay_c.pc;
    assign tr_rd    = rpay_c.rd;
    assign tr_data  = rpay_c.data;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;
    assign state    = state_q;
    assign cycle    = cycle_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: capture order, filtering, overflow,
// capture window end, clear priority and asynchronous reset.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset, arm, clear, halt, wb_valid, tr_ready;
    logic [15:0] max_cycles;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc, wb_data;
    logic        tr_valid, overflow;
    logic [15:0] tr_cycle, cycle;
    logic [31:0] tr_pc, tr_data;
    logic [4:0]  tr_rd, count;
    logic [7:0]  drop_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    trace_capture #(.DEPTH(16), .CYC_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .clear      (clear),
        .max_cycles (max_cycles),
        .halt       (halt),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_pc      (wb_pc),
        .wb_data    (wb_data),
        .tr_ready   (tr_ready),
        .tr_valid   (tr_valid),
        .tr_cycle   (tr_cycle),
        .tr_pc      (tr_pc),
        .tr_rd      (tr_rd),
        .tr_data    (tr_data),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .state      (state),
        .cycle      (cycle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_pc    = pc;
        wb_data  = d;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; clear = 1'b0; halt = 1'b0; tr_ready = 1'b0;
        max_cycles = 16'd0;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(tr_valid), 64'd0);
        chk("rst_cycle", 64'(cycle), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        reset = 1'b0;

        // Two events, consumer always ready
        arm = 1'b1; tr_ready = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state", 64'(state), 64'd1);
        chk("arm_cycle", 64'(cycle), 64'd0);
        wb(1'b1, 5'd3, 32'h0, 32'd5);
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("e0_valid", 64'(tr_valid), 64'd1);
        chk("e0_cycle", 64'(tr_cycle), 64'd0);
        chk("e0_pc", 64'(tr_pc), 64'h0);
        chk("e0_rd", 64'(tr_rd), 64'd3);
        chk("e0_data", 64'(tr_data), 64'd5);
        tick();
        chk("e0_popped", 64'(count), 64'd0);
        chk("cyc2", 64'(cycle), 64'd2);
        wb(1'b1, 5'd4, 32'h4, 32'd9);
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("e1_cycle", 64'(tr_cycle), 64'd2);
        chk("e1_pc", 64'(tr_pc), 64'h4);
        chk("e1_rd", 64'(tr_rd), 64'd4);
        chk("e1_data", 64'(tr_data), 64'd9);
        tick();
        chk("e1_popped", 64'(count), 64'd0);
        chk("e1_nvalid", 64'(tr_valid), 64'd0);

        // rd=0 is filtered
        wb(1'b1, 5'd0, 32'h8, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("rd0_count", 64'(count), 64'd0);

        // Fill past full with consumer stalled
        tr_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wb(1'b1, 5'((i % 31) + 1), 32'(i * 4), 32'(i));
            tick();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_drop", 64'(drop_cnt), 64'd2);
        chk("full_head", 64'(tr_data), 64'd0);
        wb(1'b1, 5'd7, 32'h40, 32'h77);
        tr_ready = 1'b1;
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        tr_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_drop", 64'(drop_cnt), 64'd2);
        chk("pp_head", 64'(tr_data), 64'd1);
        chk("pp_ovf", 64'(overflow), 64'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_state", 64'(state), 64'd0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_cycle", 64'(cycle), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);

        // Capture window of 7 cycles
        max_cycles = 16'd7; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("win_run", 64'(state), 64'd1);
        chk("win_cyc6", 64'(cycle), 64'd6);
        tick();
        chk("win_done", 64'(state), 64'd2);
        chk("win_hold", 64'(cycle), 64'd6);
        wb(1'b1, 5'd5, 32'h10, 32'd3);
        arm = 1'b1;
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        arm = 1'b0;
        chk("done_nocap", 64'(count), 64'd0);
        chk("done_noarm", 64'(state), 64'd2);
        chk("done_hold2", 64'(cycle), 64'd6);

        // Halt together with an event
        clear = 1'b1; max_cycles = 16'd0;
        tick();
        clear = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(); tick();
        halt = 1'b1;
        wb(1'b1, 5'd9, 32'h100, 32'hABCD);
        tick();
        halt = 1'b0;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("halt_state", 64'(state), 64'd2);
        chk("halt_count", 64'(count), 64'd1);
        chk("halt_tcyc", 64'(tr_cycle), 64'd2);
        chk("halt_rd", 64'(tr_rd), 64'd9);
        chk("halt_data", 64'(tr_data), 64'hABCD);
        chk("halt_cyc", 64'(cycle), 64'd2);

        // Async reset mid-RUN with 5 entries
        clear = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb(1'b1, 5'd2, 32'(i), 32'(i));
            tick();
        end
        chk("pre_rst_count", 64'(count), 64'd5);
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(tr_valid), 64'd0);
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_cycle", 64'(cycle), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        #1;
        reset = 1'b0;
        tick();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("post_rst_idle", 64'(state), 64'd0);
        chk("post_rst_nocap", 64'(count), 64'd0);

        // clear wins over arm
        clear = 1'b1; arm = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b0;
        chk("clr_arm_idle", 64'(state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter CYC_W, default 16, meaning cycle-stamp width.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port arm  input  1  start capture; Port clear  input  1  synchronous flush.
REQ-006 Port max_cycles  input  CYC_W  capture window length; 0 means unlimited.
REQ-007 Port halt  input  1  processor halt strobe.
REQ-008 Ports wb_valid  input  1; wb_rd  input  5; wb_pc  input  32; wb_data  input  32: processor writeback event.
REQ-009 Port tr_ready  input  1  consumer pop request.
REQ-010 Ports tr_valid  output  1; tr_cycle  output  CYC_W; tr_pc  output  32; tr_rd  output  5; tr_data  output  32: head trace entry.
REQ-011 Ports count  output  $clog2(DEPTH)+1; overflow  output  1; drop_cnt  output  8; state  output  2; cycle  output  CYC_W.

Function
REQ-012 The FSM SHALL have states IDLE=0, RUN=1, DONE=2, encoded on state.
REQ-013 IDLE->RUN SHALL occur on arm=1; arm in RUN or DONE SHALL be ignored.
REQ-014 RUN->DONE SHALL occur on halt=1, or when max_cycles!=0 and cycle==max_cycles-1 at that edge.
REQ-015 clear=1 SHALL return to IDLE, empty the FIFO and zero cycle, overflow and drop_cnt in one cycle; clear SHALL take priority over arm, halt, push and pop.
REQ-016 cycle SHALL increment by 1 each RUN cycle, wrap modulo 2^CYC_W, hold in IDLE/DONE, and load 0 on IDLE->RUN.
REQ-017 A push SHALL occur in RUN when wb_valid=1 and wb_rd!=0; entry = {cycle, wb_pc, wb_rd, wb_data} sampled that edge.
REQ-018 An event in the same cycle as the RUN->DONE transition SHALL be captured; events in IDLE/DONE SHALL be ignored.
REQ-019 The FIFO SHALL be first-word-fall-through: tr_valid = (count!=0), tr_* show the head combinationally, a pop occurs when tr_valid & tr_ready.
REQ-020 Push at full without a simultaneous pop SHALL drop the entry, set overflow (sticky until clear/reset) and increment drop_cnt, saturating at 255.
REQ-021 Push and pop in the same cycle at full SHALL both succeed; count SHALL be unchanged.
REQ-022 tr_ready with tr_valid=0 SHALL have no effect; pops SHALL be allowed in every state.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 Push-to-tr_valid latency SHALL be one clock (entry visible the cycle after the capturing edge).

Reset
REQ-025 On reset=1, asynchronously: state=IDLE, count=0, pointers=0, cycle=0, overflow=0, drop_cnt=0, tr_valid=0.
REQ-026 FIFO storage SHALL not require reset; tr_cycle/tr_pc/tr_rd/tr_data are don't-care while tr_valid=0.
REQ-027 Reset asserted mid-RUN SHALL discard all entries; capture SHALL not resume until a new arm.

Structure
REQ-028 A shared package SHALL hold the state encodings, the 5-bit register-index width, 32-bit data width and the trace-entry field layout.
REQ-029 The storage SHALL be one sub-module, trace_fifo (parameterised DEPTH/width, FWFT, full/empty/count); trace_capture contains the FSM, cycle counter and drop logic.

Verification
REQ-030 Reset, arm, wb events rd=3/pc=0x0/data=5 at cycle 0 and rd=4/pc=0x4/data=9 at cycle 2, tr_ready=1 -> entries {0,0x0,3,5} then {2,0x4,4,9} in order, count returns to 0.
REQ-031 wb_rd=0 with wb_valid=1 in RUN -> no push, count stays 0.
REQ-032 DEPTH=16, 18 events with tr_ready=0 -> count=16, overflow=1, drop_cnt=2; then one push+pop at full -> count=16, drop_cnt=2.
REQ-033 max_cycles=7, arm -> state DONE after 7 RUN cycles, cycle holds 6; halt in RUN together with an event -> event captured, state DONE.
REQ-034 Reset pulsed mid-RUN with 5 entries -> tr_valid=0, state IDLE, cycle=0 immediately; clear+arm together -> IDLE.
